// File: rtl/gumnut_inst_responder.sv
// Instruction-bus responder for the Gumnut core: on-chip 18-bit instruction
// store with a program-load port and a fetch port acked after WAIT_STATES cycles.
module gumnut_inst_responder #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_cyc_i,
  input  logic              inst_stb_i,
  input  logic [ADDR_W-1:0] inst_adr_i,
  output logic [17:0]       inst_dat_o,
  output logic              inst_ack_o,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_adr_i,
  input  logic [17:0]       ld_dat_i,
  output logic              ld_rdy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam int            CNT_W   = 4;
  localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_adr, w_adr_nxt;
  logic [17:0]       r_dat;
  logic              r_ack;
  logic [17:0]       r_mem [DEPTH];

  logic              w_ld_wr;
  logic              w_ld_in_rng;
  logic [ADDR_W-1:0] w_rd_adr;
  logic              w_rd_in_rng;
  logic [17:0]       w_rd_dat;

  assign w_ld_in_rng = {1'b0, ld_adr_i} < DEPTH_L;

  // With zero wait states the ACK entry happens straight from IDLE, so the
  // read must use the live fetch address rather than the not-yet-latched one.
  assign w_rd_adr    = (r_state == S_IDLE) ? inst_adr_i : r_adr;
  assign w_rd_in_rng = {1'b0, w_rd_adr} < DEPTH_L;
  assign w_rd_dat    = w_rd_in_rng ? r_mem[w_rd_adr[IDX_W-1:0]] : 18'h00000;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_adr_nxt = r_adr;
    w_ld_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ld_we_i) begin
          w_ld_wr = w_ld_in_rng;
        end else if (inst_cyc_i && inst_stb_i) begin
          w_adr_nxt = inst_adr_i;
          w_cnt_nxt = CNT_W'(WAIT_STATES);
          w_next    = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!inst_cyc_i) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) w_next = S_ACK;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_dat   <= 18'h00000;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_adr   <= w_adr_nxt;
      r_ack   <= (w_next == S_ACK);
      if (w_next == S_ACK) r_dat <= w_rd_dat;
    end
  end

  // Program store survives reset so a warm reset keeps the loaded image.
  always_ff @(posedge clk_i) begin
    if (w_ld_wr) r_mem[ld_adr_i[IDX_W-1:0]] <= ld_dat_i;
  end

  assign inst_dat_o = r_dat;
  assign inst_ack_o = r_ack;
  assign ld_rdy_o   = (r_state == S_IDLE);

endmodule

// File: tb/tb_gumnut_inst_responder.sv
// Bench for gumnut_inst_responder: four instances with different wait-state
// and depth settings, checked against a transaction-level memory/latency model.
module tb_gumnut_inst_responder;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]        cyc, stb, we;
  logic [N-1:0][11:0]  adr, ladr;
  logic [N-1:0][17:0]  ldat;
  wire  [N-1:0][17:0]  dat;
  wire  [N-1:0]        ack, rdy;

  int checks = 0;
  int errors = 0;

  logic [17:0] mm [N][4096];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    gumnut_inst_responder #(
      .ADDR_W(12),
      .DEPTH((g == 3) ? 256 : 4096),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 2)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .inst_cyc_i(cyc[g]), .inst_stb_i(stb[g]), .inst_adr_i(adr[g]),
      .inst_dat_o(dat[g]), .inst_ack_o(ack[g]),
      .ld_we_i(we[g]), .ld_adr_i(ladr[g]), .ld_dat_i(ldat[g]),
      .ld_rdy_o(rdy[g])
    );
  end

  function automatic int ws(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 3 : 2;
  endfunction

  function automatic int dp(int k);
    return (k == 3) ? 256 : 4096;
  endfunction

  task automatic do_load(int k, logic [11:0] a, logic [17:0] d);
    int n;
    @(negedge clk);
    we[k] = 1'b1; ladr[k] = a; ldat[k] = d;
    n = 0;
    while (!rdy[k] && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!rdy[k]) begin errors++; $display("FAIL load_rdy_timeout inst%0d: got %b expected 1", k, rdy[k]); end
    @(posedge clk); #1;
    we[k] = 1'b0;
    if (int'(a) < dp(k)) mm[k][a] = d;
  endtask

  task automatic do_fetch(int k, logic [11:0] a);
    int n;
    logic [17:0] exp;
    exp = (int'(a) < dp(k)) ? mm[k][a] : 18'h00000;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; adr[k] = a;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack[k] && n < 40);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    checks++;
    if (n != ws(k) + 1) begin errors++; $display("FAIL fetch_latency inst%0d adr %h: got %0d expected %0d", k, a, n, ws(k) + 1); end
    checks++;
    if (dat[k] !== exp) begin errors++; $display("FAIL fetch_data inst%0d adr %h: got %h expected %h", k, a, dat[k], exp); end
    @(posedge clk); #1;
    checks++;
    if (ack[k] !== 1'b0) begin errors++; $display("FAIL ack_one_cycle inst%0d: got %b expected 0", k, ack[k]); end
    checks++;
    if (dat[k] !== exp) begin errors++; $display("FAIL data_held inst%0d: got %h expected %h", k, dat[k], exp); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ack[k] !== 1'b0) begin errors++; $display("FAIL reset_ack inst%0d: got %b expected 0", k, ack[k]); end
      checks++;
      if (dat[k] !== 18'h00000) begin errors++; $display("FAIL reset_dat inst%0d: got %h expected 00000", k, dat[k]); end
      checks++;
      if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_rdy inst%0d: got %b expected 1", k, rdy[k]); end
    end
  endtask

  task automatic test_basic();
    do_load(0, 12'h010, 18'h3A5C0);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 12'h010;
    @(posedge clk); #1;
    checks++;
    if (ack[0] !== 1'b0) begin errors++; $display("FAIL basic_ack_c1: got %b expected 0", ack[0]); end
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    checks++;
    if (ack[0] !== 1'b1) begin errors++; $display("FAIL basic_ack_c2: got %b expected 1", ack[0]); end
    checks++;
    if (dat[0] !== 18'h3A5C0) begin errors++; $display("FAIL basic_dat: got %h expected 3a5c0", dat[0]); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack[0] !== 1'b0 || dat[0] !== 18'h3A5C0) begin
        errors++; $display("FAIL basic_hold: got ack %b dat %h expected ack 0 dat 3a5c0", ack[0], dat[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_d [2];
    exp_d[0] = 18'h00001; exp_d[1] = 18'h00002;
    do_load(1, 12'h000, 18'h00001);
    do_load(1, 12'h001, 18'h00002);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 12'h000;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ack[1] !== ((c % 2) == 1)) begin errors++; $display("FAIL b2b_ack_c%0d: got %b expected %b", c, ack[1], (c % 2) == 1); end
      if (c % 2 == 1) begin
        checks++;
        if (dat[1] !== exp_d[c / 2]) begin errors++; $display("FAIL b2b_dat_c%0d: got %h expected %h", c, dat[1], exp_d[c / 2]); end
        adr[1] = 12'h001;
        if (c == 3) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
      end
    end
  endtask

  task automatic test_abort();
    logic [17:0] held;
    do_load(2, 12'h030, 18'h0BEEF);
    do_load(2, 12'h031, 18'h2C0DE);
    do_fetch(2, 12'h030);
    held = mm[2][12'h030];
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 12'h031;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy[2] !== 1'b1) begin errors++; $display("FAIL abort_idle: got rdy %b expected 1", rdy[2]); end
    checks++;
    if (dat[2] !== held) begin errors++; $display("FAIL abort_dat: got %h expected %h", dat[2], held); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ack[2] !== 1'b0) begin errors++; $display("FAIL abort_noack c%0d: got %b expected 0", i, ack[2]); end
      @(posedge clk); #1;
    end
    do_fetch(2, 12'h031);
  endtask

  task automatic test_load_priority();
    @(negedge clk);
    we[0] = 1'b1; ladr[0] = 12'h020; ldat[0] = 18'h1FFFF;
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 12'h020;
    @(posedge clk); #1;
    we[0] = 1'b0;
    mm[0][12'h020] = 18'h1FFFF;
    checks++;
    if (ack[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++; $display("FAIL prio_not_accepted: got ack %b rdy %b expected ack 0 rdy 1", ack[0], rdy[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL prio_accepted: got rdy %b expected 0", rdy[0]); end
    we[0] = 1'b1; ladr[0] = 12'h020; ldat[0] = 18'h12345;
    @(posedge clk); #1;
    checks++;
    if (ack[0] !== 1'b1) begin errors++; $display("FAIL prio_ack: got %b expected 1", ack[0]); end
    checks++;
    if (dat[0] !== 18'h1FFFF) begin errors++; $display("FAIL prio_dat: got %h expected 1ffff", dat[0]); end
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL prio_busy_rdy: got %b expected 0", rdy[0]); end
    we[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
    do_fetch(0, 12'h020);
  endtask

  task automatic test_out_of_range();
    do_load(3, 12'h000, 18'h2AAAA);
    do_load(3, 12'h100, 18'h3FFFF);
    do_fetch(3, 12'h000);
    do_fetch(3, 12'h100);
    do_fetch(3, 12'h000);
    do_fetch(3, 12'hFFF);
  endtask

  task automatic test_random();
    logic [11:0] wq[$];
    logic [11:0] a;
    for (int k = 0; k < N; k++) begin
      wq.delete();
      for (int i = 0; i < 10; i++) begin
        a = 12'($urandom_range(0, 63));
        if (k == 3 && ($urandom % 4) == 0) a = 12'h100 + 12'($urandom_range(0, 255));
        do_load(k, a, 18'($urandom));
        if (int'(a) < dp(k)) wq.push_back(a);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (wq.size() == 0 || (k == 3 && ($urandom % 4) == 0))
          do_fetch(k, 12'h100 + 12'($urandom_range(0, 255)) * ((k == 3) ? 12'd1 : 12'd0));
        else
          do_fetch(k, wq[$urandom_range(0, wq.size() - 1)]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load(3, 12'h005, 18'h15555);
    do_fetch(3, 12'h005);
    @(negedge clk);
    cyc[3] = 1'b1; stb[3] = 1'b1; adr[3] = 12'h000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[3] !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", ack[3]); end
    checks++;
    if (dat[3] !== 18'h00000) begin errors++; $display("FAIL rst_mid_dat: got %h expected 00000", dat[3]); end
    cyc[3] = 1'b0; stb[3] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack[3] !== 1'b0) begin errors++; $display("FAIL rst_mid_noack c%0d: got %b expected 0", i, ack[3]); end
    end
    do_fetch(3, 12'h005);
    do_fetch(3, 12'h000);
    do_fetch(0, 12'h010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; adr = '0; ladr = '0; ldat = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_load_priority();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gumnut_inst_responder.md
# gumnut_inst_responder

Instruction-bus responder for the Gumnut datapath. It answers fetch requests issued by the core's instruction port (cyc/stb/address in, 18-bit instruction and ack out) with a programmable number of wait states. It contains an on-chip 18-bit instruction store and a program-load write port used by the boot loader and test benches. It sits between the core's fetch logic and the program memory, and is the sole source of the core's instruction-acknowledge signal.

## Interface

Parameters:
- ADDR_W, 12, instruction address width in bits
- DEPTH, 4096, number of 18-bit words implemented; must be ≤ 2^ADDR_W
- WAIT_STATES, 1, cycles inserted between request accept and ack; valid range 0–15

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- inst_cyc_i  in  1  bus cycle in progress, from the core
- inst_stb_i  in  1  fetch strobe, from the core
- inst_adr_i  in  ADDR_W  fetch address
- inst_dat_o  out  18  fetched instruction word
- inst_ack_o  out  1  one-cycle fetch acknowledge
- ld_we_i  in  1  program-load write enable
- ld_adr_i  in  ADDR_W  program-load address
- ld_dat_i  in  18  program-load data
- ld_rdy_o  out  1  high when a load write is accepted this cycle

## Operation

- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - ld_rdy_o = 1.
  - If ld_we_i = 1, write mem[ld_adr_i] <= ld_dat_i and stay in IDLE.
  - A same-cycle fetch is not accepted; the load has priority and the fetch is taken on a later IDLE cycle while cyc/stb remain high.
  - Otherwise, if inst_cyc_i & inst_stb_i: latch inst_adr_i into the address register and load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES > 0, otherwise ACK.
- WAIT:
  - Counter decrements by 1 per cycle.
  - When the counter reaches 1 and is decremented, next state is ACK.
  - If inst_cyc_i drops, abort: return to IDLE, no ack, inst_dat_o unchanged.
- ACK:
  - inst_ack_o = 1 for exactly this cycle.
  - inst_dat_o = mem[latched address], registered on entry to ACK and held afterwards.
  - Next state is always IDLE, so a strobe still high one cycle after ack starts a new fetch.
  - A cyc drop during ACK does not suppress the ack.
- Out-of-range latched address (≥ DEPTH): inst_dat_o = 18'h00000; ack timing unchanged.
- Load address ≥ DEPTH: write discarded.
- ld_we_i outside IDLE: ignored (ld_rdy_o = 0); the loader must hold ld_we_i until ld_rdy_o = 1.
- Memory contents are not cleared by reset.
- Address and data inputs are sampled only at accept; later changes during WAIT have no effect.

## Timing

- Reset values:
  - state IDLE
  - inst_ack_o 0
  - inst_dat_o 18'h00000
  - ld_rdy_o 1
  - wait counter 0
  - address register 0
- Reset asserted mid-fetch: ack is never produced for that fetch, and memory is intact.
- Fetch latency: stb sampled high in IDLE at edge N gives inst_ack_o high during cycle N+1+WAIT_STATES.
  - WAIT_STATES = 0: ack in the cycle after accept.
- Back-to-back throughput: one fetch per WAIT_STATES+2 cycles.
- ld_rdy_o is combinational from state only.
- inst_dat_o and inst_ack_o are registered.

## Test plan

- Reset, then with WAIT_STATES=1: load 18'h3A5C0 at 12'h010; fetch 12'h010 with stb at edge 0 → ack high in cycle 2 only, inst_dat_o = 18'h3A5C0, held after ack.
- WAIT_STATES=0, strobe held high across fetches of 12'h000 then 12'h001 (preloaded 18'h00001 and 18'h00002) → acks in cycles 1 and 3, data 18'h00001 then 18'h00002, never two consecutive ack cycles.
- WAIT_STATES=3: drop inst_cyc_i one cycle after accept → no ack, FSM in IDLE next cycle, inst_dat_o unchanged; a subsequent fetch acks after 4 cycles.
- Assert ld_we_i (addr 12'h020, data 18'h1FFFF) in the same cycle as a fetch strobe in IDLE → write completes, fetch accepted next cycle; ld_we_i raised during WAIT → ld_rdy_o = 0 and the memory word unchanged.
- DEPTH=256: fetch 12'h100 → ack with 18'h00000; load to 12'h100 discarded; reading 12'h000 is unaffected.
- Pull rst_i low during WAIT with WAIT_STATES=2 → inst_ack_o and inst_dat_o go to 0 immediately without a clock edge, no ack after release, and previously loaded words are still readable.
